// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
//
// Shares the register file's single write port between NUM_REQ write-back
// sources (ALU, load unit, multiplier, ...). Index 0 has the highest static
// priority. A requester stalled for STARVE_LIMIT consecutive cycles is
// escalated above all non-escalated requesters. The winning write is
// registered before it reaches the register file.
//
// Requests with a zero destination register are accepted immediately and
// dropped; they never compete for the port. The register file has no write
// enable, so an idle cycle drives wr_rd = 0.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   reset      synchronous, active-high reset
//   req_valid  per-requester write request
//   req_rd     per-requester destination register
//   req_data   per-requester write data
//   req_ready  combinational accept per requester (all-zero during reset)
//   wr_rd      registered write index, 0 = no write
//   wr_data    registered write data
//   wr_valid   registered, high when wr_rd/wr_data carry an accepted write
//   wr_src     registered index of the requester that produced the write
// -----------------------------------------------------------------------------
package PARAMS_pkg;
    localparam int WD_SIZE        = 32;
    localparam int INSTR_REG_BITS = 5;
endpackage

module wb_port_arbiter
    import PARAMS_pkg::*;
#(
    parameter int  NUM_REQ      = 3,
    parameter int  STARVE_LIMIT = 4,
    localparam int SRC_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_REQ-1:0]                     req_valid,
    input  logic [NUM_REQ-1:0][INSTR_REG_BITS-1:0] req_rd,
    input  logic [NUM_REQ-1:0][WD_SIZE-1:0]        req_data,
    output logic [NUM_REQ-1:0]                     req_ready,
    output logic [INSTR_REG_BITS-1:0]              wr_rd,
    output logic [WD_SIZE-1:0]                     wr_data,
    output logic                                   wr_valid,
    output logic [SRC_W-1:0]                       wr_src
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    // Per-requester consecutive-stall counters.
    logic [NUM_REQ-1:0][CNT_W-1:0] cnt_q, cnt_d;

    // Output stage.
    logic [INSTR_REG_BITS-1:0] wr_rd_q, wr_rd_d;
    logic [WD_SIZE-1:0]        wr_data_q, wr_data_d;
    logic                      wr_valid_q, wr_valid_d;
    logic [SRC_W-1:0]          wr_src_q, wr_src_d;

    logic [NUM_REQ-1:0] real_req;   // valid with rd != 0: competes for the port
    logic [NUM_REQ-1:0] drop_req;   // valid with rd == 0: accepted and discarded
    logic [NUM_REQ-1:0] escalated;
    logic [NUM_REQ-1:0] pool;
    logic [NUM_REQ-1:0] grant;
    logic [SRC_W-1:0]   grant_idx;
    logic               any_grant;

    // NOTE: combinational blocks use blocking assignments and give every
    // output a default first, so no path can leave a latch behind.
    always_comb begin
        real_req  = '0;
        drop_req  = '0;
        escalated = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            real_req[i]  = req_valid[i] && (req_rd[i] != '0);
            drop_req[i]  = req_valid[i] && (req_rd[i] == '0);
            escalated[i] = real_req[i] && (cnt_q[i] == LIMIT);
        end
    end

    // Escalated candidates, if any, form the whole candidate pool; the lowest
    // index in the pool wins. Scanning downwards leaves the lowest index.
    always_comb begin
        pool      = (|escalated) ? escalated : real_req;
        any_grant = |real_req;
        grant_idx = '0;
        grant     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (pool[i]) begin
                grant_idx = SRC_W'(i);
            end
        end
        if (any_grant) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        req_ready = reset ? '0 : (drop_req | grant);
    end

    // Counters clear when the requester is idle or wins, otherwise count up
    // and saturate at the limit.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!real_req[i] || grant[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] != LIMIT) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Without a grant, wr_data and wr_src hold: the register file ignores
    // them when wr_rd is 0, and holding avoids needless toggling.
    always_comb begin
        wr_rd_d    = '0;
        wr_valid_d = 1'b0;
        wr_data_d  = wr_data_q;
        wr_src_d   = wr_src_q;
        if (any_grant) begin
            wr_rd_d    = req_rd[grant_idx];
            wr_data_d  = req_data[grant_idx];
            wr_valid_d = 1'b1;
            wr_src_d   = grant_idx;
        end
    end

    // NOTE: state is updated with non-blocking assignments; reset clears
    // every register here, including a write staged just before reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            wr_rd_q    <= '0;
            wr_data_q  <= '0;
            wr_valid_q <= 1'b0;
            wr_src_q   <= '0;
        end else begin
            cnt_q      <= cnt_d;
            wr_rd_q    <= wr_rd_d;
            wr_data_q  <= wr_data_d;
            wr_valid_q <= wr_valid_d;
            wr_src_q   <= wr_src_d;
        end
    end

    assign wr_rd    = wr_rd_q;
    assign wr_data  = wr_data_q;
    assign wr_valid = wr_valid_q;
    assign wr_src   = wr_src_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_port_arbiter
//
// Directed scenarios followed by randomized traffic. A reference model tracks
// how long each pending request has been waiting and picks the winner from
// that; expected outputs and a model register file come from the model.
// -----------------------------------------------------------------------------
module tb_wb_port_arbiter;
    import PARAMS_pkg::*;

    localparam int N     = 3;
    localparam int LIMIT = 4;

    logic                                 clk = 1'b0;
    logic                                 reset;
    logic [N-1:0]                         req_valid;
    logic [N-1:0][INSTR_REG_BITS-1:0]     req_rd;
    logic [N-1:0][WD_SIZE-1:0]            req_data;
    logic [N-1:0]                         req_ready;
    logic [INSTR_REG_BITS-1:0]            wr_rd;
    logic [WD_SIZE-1:0]                   wr_data;
    logic                                 wr_valid;
    logic [1:0]                           wr_src;

    always #5 clk = ~clk;

    wb_port_arbiter #(
        .NUM_REQ      (N),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_rd    (req_rd),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr_rd     (wr_rd),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_src    (wr_src)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Register file fed by the DUT, and the model's own register file.
    logic [WD_SIZE-1:0] dut_rf   [32];
    int                 dut_wcnt [32];
    logic [WD_SIZE-1:0] model_rf [32];

    always @(posedge clk) begin
        if (wr_rd != '0) begin
            dut_rf[wr_rd]   <= wr_data;
            dut_wcnt[wr_rd] <= dut_wcnt[wr_rd] + 1;
        end
    end

    // Reference model state: cycles each pending request has waited, and the
    // write the output stage should be presenting.
    int                        age [N];
    logic [INSTR_REG_BITS-1:0] exp_rd;
    logic [WD_SIZE-1:0]        exp_data;
    logic                      exp_valid;
    logic [1:0]                exp_src;
    logic [N-1:0]              last_ready;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic [INSTR_REG_BITS-1:0] rd,
                           input logic [WD_SIZE-1:0] d);
        req_valid[i] = 1'b1;
        req_rd[i]    = rd;
        req_data[i]  = d;
    endtask

    // One clock cycle: compare at the falling edge, advance the model at the
    // rising edge, then retire the accepted requests.
    task automatic step();
        int           g;
        logic [N-1:0] exp_ready;
        @(negedge clk);
        g = -1;
        if (!reset) begin
            for (int i = 0; i < N; i++)
                if (g < 0 && req_valid[i] && req_rd[i] != 0 && age[i] >= LIMIT) g = i;
            for (int i = 0; i < N; i++)
                if (g < 0 && req_valid[i] && req_rd[i] != 0) g = i;
        end
        exp_ready = '0;
        if (!reset)
            for (int i = 0; i < N; i++)
                exp_ready[i] = req_valid[i] && (req_rd[i] == 0 || i == g);
        last_ready = req_ready;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("wr_rd",     32'(wr_rd),     32'(exp_rd));
        check("wr_data",   wr_data,        exp_data);
        check("wr_valid",  32'(wr_valid),  32'(exp_valid));
        check("wr_src",    32'(wr_src),    32'(exp_src));
        @(posedge clk);
        if (exp_rd != 0) model_rf[exp_rd] = exp_data;
        if (reset) begin
            exp_rd = '0; exp_data = '0; exp_valid = 1'b0; exp_src = '0;
            for (int i = 0; i < N; i++) age[i] = 0;
        end else begin
            if (g >= 0) begin
                exp_rd    = req_rd[g];
                exp_data  = req_data[g];
                exp_valid = 1'b1;
                exp_src   = 2'(g);
            end else begin
                exp_rd    = '0;
                exp_valid = 1'b0;
            end
            for (int i = 0; i < N; i++)
                age[i] = (req_valid[i] && req_rd[i] != 0 && i != g) ? age[i] + 1 : 0;
        end
        #1;
        for (int i = 0; i < N; i++)
            if (exp_ready[i]) req_valid[i] = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_rd    = '0;
        req_data  = '0;
        exp_rd    = '0;
        exp_data  = '0;
        exp_valid = 1'b0;
        exp_src   = '0;
        for (int i = 0; i < N; i++) age[i] = 0;
        for (int r = 0; r < 32; r++) begin
            dut_rf[r]   = '0;
            dut_wcnt[r] = 0;
            model_rf[r] = '0;
        end

        // Reset state.
        step();
        step();
        check("reset_wr_valid", 32'(wr_valid), 0);
        check("reset_wr_rd", 32'(wr_rd), 0);
        reset = 1'b0;
        step();

        // Fixed priority: 0, then 1, then 2 on consecutive cycles.
        set_req(0, 5'd3, 32'h11);
        set_req(1, 5'd4, 32'h22);
        set_req(2, 5'd5, 32'h33);
        step();
        check("prio_ready0", 32'(last_ready), 32'b001);
        check("prio_rd0", 32'(wr_rd), 3);
        check("prio_data0", wr_data, 32'h11);
        check("prio_src0", 32'(wr_src), 0);
        step();
        check("prio_ready1", 32'(last_ready), 32'b010);
        check("prio_rd1", 32'(wr_rd), 4);
        check("prio_data1", wr_data, 32'h22);
        check("prio_src1", 32'(wr_src), 1);
        step();
        check("prio_ready2", 32'(last_ready), 32'b100);
        check("prio_rd2", 32'(wr_rd), 5);
        check("prio_data2", wr_data, 32'h33);
        check("prio_src2", 32'(wr_src), 2);
        step();

        // Starvation: req2 stalls four cycles behind a busy req0, then wins.
        set_req(2, 5'd9, 32'h99);
        for (int c = 0; c < 6; c++) begin
            if (!req_valid[0]) set_req(0, 5'(10 + c), 32'(c));
            step();
            if (c < 4) begin
                check("starve_stall", 32'(last_ready[2]), 0);
                check("starve_req0_rd", 32'(wr_rd), 32'(10 + c));
            end else if (c == 4) begin
                check("starve_grant", 32'(last_ready), 32'b100);
                check("starve_rd9", 32'(wr_rd), 9);
                check("starve_data", wr_data, 32'h99);
            end else begin
                check("starve_resume", 32'(last_ready[0]), 1);
                check("starve_resume_rd", 32'(wr_rd), 14);
            end
        end
        step();

        // Zero-destination drop alongside a real request.
        set_req(0, 5'd0, 32'h77);
        set_req(1, 5'd6, 32'h66);
        step();
        check("drop_ready", 32'(last_ready), 32'b011);
        check("drop_rd", 32'(wr_rd), 6);
        check("drop_data", wr_data, 32'h66);
        check("drop_src", 32'(wr_src), 1);

        // Single write to x2, then idle.
        set_req(0, 5'd2, 32'h5);
        step();
        check("idle_pre_rd", 32'(wr_rd), 2);
        for (int k = 0; k < 3; k++) begin
            step();
            check("idle_rd", 32'(wr_rd), 0);
            check("idle_valid", 32'(wr_valid), 0);
        end
        check("x2_value", dut_rf[2], 32'h5);
        check("x2_writes", 32'(dut_wcnt[2]), 1);

        // Same destination from two sources lands in grant order.
        set_req(1, 5'd8, 32'h1);
        set_req(2, 5'd8, 32'h2);
        step();
        check("same_rd_first", wr_data, 32'h1);
        check("same_rd_src1", 32'(wr_src), 1);
        step();
        check("same_rd_second", wr_data, 32'h2);
        check("same_rd_src2", 32'(wr_src), 2);
        step();
        step();
        check("x8_value", dut_rf[8], 32'h2);

        // Reset one cycle after a grant discards the staged write.
        set_req(1, 5'd7, 32'hAA);
        step();
        check("rst_mid_rd7", 32'(wr_rd), 7);
        reset = 1'b1;
        set_req(0, 5'd10, 32'h1);
        step();
        check("rst_mid_ready", 32'(last_ready), 0);
        check("rst_mid_wr_rd", 32'(wr_rd), 0);
        check("rst_mid_valid", 32'(wr_valid), 0);
        reset = 1'b0;
        step();
        check("rst_after_rd", 32'(wr_rd), 10);

        // Randomized traffic with a busy req0 to exercise escalation.
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 3) < ((i == 0) ? 3 : 1))
                    set_req(i, ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                            32'($urandom));
            end
            step();
        end
        reset     = 1'b0;
        req_valid = '0;
        step();
        step();
        step();
        for (int r = 1; r < 32; r++)
            check("rf_final", dut_rf[r], model_rf[r]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the register file's single write port (wr_rd/wr_data) between NUM_REQ write-back sources, e.g. ALU, load unit and multiplier.
- Uses fixed priority with starvation escalation, plus a registered output stage.
- Sits between the execution units and the register file. The register file has no write enable, so an idle cycle drives wr_rd=0; writes to x0 are ignored.

Parameters:
- NUM_REQ, 3, number of write-back requesters; index 0 has the highest static priority.
- STARVE_LIMIT, 4, consecutive stalled cycles after which a requester is escalated. Legal range 1..15.
- WD_SIZE, from PARAMS_pkg (32), data width.
- INSTR_REG_BITS, from PARAMS_pkg (5), register index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester write request.
- req_rd  in  NUM_REQ x INSTR_REG_BITS  destination register per requester.
- req_data  in  NUM_REQ x WD_SIZE  write data per requester.
- req_ready  out  NUM_REQ  combinational grant/accept per requester.
- wr_rd  out  INSTR_REG_BITS  registered register-file write index; 0 = no write.
- wr_data  out  WD_SIZE  registered register-file write data.
- wr_valid  out  1  registered; high when wr_rd/wr_data carry an accepted nonzero-rd write.
- wr_src  out  clog2(NUM_REQ)  registered index of the requester that produced the current write.

Behaviour:
- Reset (reset=1 at a clock edge):
  - wr_rd=0, wr_data=0, wr_valid=0, wr_src=0.
  - All starvation counters = 0.
  - req_ready is forced to all-zero combinationally while reset=1.
  - A write staged before reset is discarded: outputs are 0 in the cycle after the reset edge.
- Handshake: a transfer occurs when req_valid[i] && req_ready[i]. Requesters hold valid, rd and data stable until accepted; the arbiter need not tolerate withdrawal.
- Zero-destination requests (req_valid[i] && req_rd[i]==0):
  - Are dropped: req_ready[i]=1 in the same cycle.
  - Do not compete for the port and do not change the outputs.
  - Any number of them may be accepted in one cycle.
- Real requests (rd!=0) compete; exactly one is granted per cycle when any exists.
- Grant selection:
  - Candidates with starve_cnt[i]==STARVE_LIMIT are escalated. If any are escalated, grant the lowest-index escalated candidate.
  - Otherwise grant the lowest-index candidate.
- Starvation counters, per requester, width clog2(STARVE_LIMIT+1):
  - Cleared when not (valid && rd!=0), or when granted.
  - Otherwise incremented, saturating at STARVE_LIMIT.
- Output stage, next clock edge after a grant:
  - wr_rd<=granted rd, wr_data<=granted data, wr_valid<=1, wr_src<=granted index.
  - If there is no grant: wr_rd<=0, wr_valid<=0. wr_data and wr_src hold their values (don't-care for the register file).
- Latency: accept at cycle N produces the register-file write at edge N+2 (output register, then register file).
  - Sustained throughput is 1 write/cycle.
  - Back-to-back writes to the same rd from different requesters land in grant order.
- Arithmetic: no comparison on data. The only comparison on rd is ==0. Counters never wrap.

Test Plan:
- Reset mid-operation:
  - Stimulus: grant req1 (rd=7, data=0xAA) in cycle N; assert reset in cycle N+1.
  - Required response: wr_rd=0, wr_valid=0 after that edge; req_ready=0 during reset; counters=0.
- Fixed priority:
  - Stimulus: req0 (rd=3, 0x11), req1 (rd=4, 0x22) and req2 (rd=5, 0x33) all valid from cycle 0.
  - Required response: grants in order 0, 1, 2. Outputs (3,0x11), (4,0x22), (5,0x33) on consecutive cycles 1, 2, 3 with wr_src 0, 1, 2.
- Starvation escalation, STARVE_LIMIT=4:
  - Stimulus: req0 valid every cycle with a new rd; req2 (rd=9, 0x99) held valid from cycle 0.
  - Required response: req2 is stalled in cycles 0–3 and granted in cycle 4. wr_rd=9 at cycle 5; req0 resumes at cycle 5.
- Zero-destination drop:
  - Stimulus: req0 rd=0 and req1 rd=6 (0x66) valid in the same cycle.
  - Required response: req_ready=3'b011 in that cycle. Next cycle wr_rd=6, wr_data=0x66, wr_src=1; no write to x0.
- Idle:
  - Stimulus: no valid requests for 3 cycles after a write of (rd=2, 0x5).
  - Required response: wr_rd=0 and wr_valid=0 in all 3 cycles; register x2 unchanged after its single write.
- Same rd from two sources:
  - Stimulus: req1 (rd=8, 0x1) and req2 (rd=8, 0x2) valid in the same cycle.
  - Required response: req1 is written first, then req2; the register file holds 0x2 for x8.
